// File: rtl/sync_fifo_sdp.sv
// Purpose: parametrised single-clock FIFO with LUT simple-dual-port storage, count-derived flags and an optional FWFT output stage.
// Latency: standard mode returns data on the cycle after an accepted read; in FWFT mode a word written to an empty FIFO is visible two edges later.
// Backpressure: never stalls. Writes while full are dropped and flagged on o_ovf. Reads while empty are ignored and flagged on o_udf.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_clr             synchronous flush: empties the FIFO; ov_rdata keeps its value
//   i_wr, iv_wdata    write request and data
//   i_rd              read request (standard mode) or pop of the head word (FWFT mode)
//   ov_rdata          read data (standard mode) or head word while o_empty=0 (FWFT mode)
//   o_full, o_empty   status flags. In FWFT mode o_empty means the output stage is empty.
//   o_afull, o_aempty o_afull: count >= p_AF_LVL. o_aempty: count <= p_AE_LVL.
//   ov_count          stored entries, 0..2**p_AW. This includes the FWFT output stage.
//   o_ovf, o_udf      single-cycle strobes for a rejected write or a rejected read
module sync_fifo_sdp #(
  parameter int p_DW     = 8,
  parameter int p_AW     = 3,
  parameter int p_FWFT   = 0,
  parameter int p_AF_LVL = 2**p_AW - 1,
  parameter int p_AE_LVL = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_wr,
  input  logic [p_DW-1:0]   iv_wdata,
  input  logic              i_rd,
  output logic [p_DW-1:0]   ov_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_afull,
  output logic              o_aempty,
  output logic [p_AW:0]     ov_count,
  output logic              o_ovf,
  output logic              o_udf
);

  localparam int DEPTH = 2**p_AW;
  localparam int CW    = p_AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(p_AF_LVL);
  localparam logic [CW-1:0] AE_C    = CW'(p_AE_LVL);

  logic [p_DW-1:0] mem [DEPTH];

  logic [p_AW-1:0] wr_ptr_q;
  logic [p_AW-1:0] rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_nxt;
  logic [p_DW-1:0] rdata_q;
  logic            full_q;
  logic            empty_q;
  logic            afull_q;
  logic            aempty_q;
  logic            ovf_q;
  logic            udf_q;

  logic            flush;
  logic            wr_acc;
  logic            rd_acc;
  logic            mem_rd;
  logic            empty_nxt;

  assign flush  = i_rst | i_clr;
  // Acceptance uses the registered flags only. A read in the same cycle
  // never makes room for a write, and a write never feeds a read.
  assign wr_acc = i_wr & ~full_q;
  assign rd_acc = i_rd & ~empty_q;

  // The total count moves with accepted writes and accepted reads or pops.
  // The extra bit holds the value 2**p_AW, so the count never wraps.
  assign cnt_nxt = cnt_q + CW'(wr_acc) - CW'(rd_acc);

  generate
    if (p_FWFT != 0) begin : g_fwft
      logic          stage_vld_q;
      logic          stage_vld_nxt;
      logic [CW-1:0] mem_cnt_q;

      // Refill the output stage whenever it is, or is about to become, empty
      // and the memory holds a word that was written on an earlier edge.
      assign mem_rd        = (~stage_vld_q | rd_acc) & (mem_cnt_q != '0);
      assign stage_vld_nxt = mem_rd | (stage_vld_q & ~rd_acc);
      assign empty_nxt     = ~stage_vld_nxt;

      always_ff @(posedge i_clk) begin
        if (flush) begin
          stage_vld_q <= 1'b0;
          mem_cnt_q   <= '0;
        end else begin
          stage_vld_q <= stage_vld_nxt;
          mem_cnt_q   <= mem_cnt_q + CW'(wr_acc) - CW'(mem_rd);
        end
      end
    end else begin : g_std
      assign mem_rd    = rd_acc;
      assign empty_nxt = (cnt_nxt == '0);
    end
  endgenerate

  // Storage has no reset, so it can map onto LUT RAM. An accepted write
  // never targets the slot being read: a write needs a free slot, and a read
  // needs an older valid slot.
  always_ff @(posedge i_clk) begin
    if (wr_acc && !flush) begin
      mem[wr_ptr_q] <= iv_wdata;
    end
  end

  // The read data register serves as the standard-mode output register and
  // as the FWFT data stage. A flush keeps its contents.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_q <= '0;
    end else if (!i_clr && mem_rd) begin
      rdata_q <= mem[rd_ptr_q];
    end
  end

  // Pointers, count and registered flags. The flags come from the next count,
  // so they line up with ov_count in every cycle.
  always_ff @(posedge i_clk) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (mem_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q    <= cnt_nxt;
      full_q   <= (cnt_nxt == DEPTH_C);
      empty_q  <= empty_nxt;
      afull_q  <= (cnt_nxt >= AF_C);
      aempty_q <= (cnt_nxt <= AE_C);
      ovf_q    <= i_wr & full_q;
      udf_q    <= i_rd & empty_q;
    end
  end

  assign ov_rdata = rdata_q;
  assign o_full   = full_q;
  assign o_empty  = empty_q;
  assign o_afull  = afull_q;
  assign o_aempty = aempty_q;
  assign ov_count = cnt_q;
  assign o_ovf    = ovf_q;
  assign o_udf    = udf_q;

endmodule
